// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and frame-check helper for the PS/2 receiver.
package ps2_pkg;

    localparam int unsigned PS2_FRAME_BITS         = 11;
    localparam logic [7:0]  PS2_BREAK_CODE         = 8'hF0;
    localparam logic [7:0]  PS2_EXT_CODE           = 8'hE0;
    localparam int unsigned PS2_FIFO_DEPTH_DEFAULT = 8;

    typedef enum logic {
        S_IDLE,
        S_RECV
    } ps2_state_e;

    // Odd parity: the data bits plus the parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous FIFO with an extra pointer MSB to tell full from empty.
// Head byte is read combinationally; storage is cleared by reset.
module ps2_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // Next-state: write when not full, read when not empty, both allowed together.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (rd_en && !empty) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // State registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: 3-flop synchronizers, 11-bit frame FSM, scan-code FIFO.
// Optional feature macro: PS2_RX_TIMEOUT_EN enables discarding stalled partial frames.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = PS2_FIFO_DEPTH_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam logic [3:0] LastBit = 4'(PS2_FRAME_BITS - 1);

    // Synchronizer chains: bit 0 is stage 1, bit 2 is stage 3.
    logic [2:0] clk_sync_q, clk_sync_d;
    logic [2:0] data_sync_q, data_sync_d;

    ps2_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [9:0] shift_q, shift_d;
    logic       overflow_q, overflow_d;
    logic       frame_err_q, frame_err_d;

    logic       fall;
    logic       bit_in;
    logic       frame_ok;
    logic       push;
    logic       fifo_empty;
    logic       fifo_full;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int unsigned TW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    assign fall   = !clk_sync_q[1] && clk_sync_q[2];
    assign bit_in = data_sync_q[2];

    // shift_q[0]=start, [8:1]=data, [9]=parity; the stop bit is the live input on the last edge.
    assign frame_ok = !shift_q[0] && bit_in && odd_parity_ok(shift_q[8:1], shift_q[9]);

    // Next-state for synchronizers, frame FSM, sticky overflow and error pulse.
    always_comb begin
        clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
        data_sync_d = {data_sync_q[1:0], ps2_data};
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
        idle_cnt_d  = '0;
`endif
        if (fall) begin
            unique case (state_q)
                S_IDLE: begin
                    shift_d = {bit_in, shift_q[9:1]};
                    cnt_d   = 4'd1;
                    state_d = S_RECV;
                end
                S_RECV: begin
                    if (cnt_q == LastBit) begin
                        if (frame_ok) begin
                            push = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        shift_d = {bit_in, shift_q[9:1]};
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
`ifdef PS2_RX_TIMEOUT_EN
        else if (state_q == S_RECV) begin
            // A stalled partial frame is dropped silently.
            if (idle_cnt_q == TimeoutLast) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end
`endif
        // Fullness is judged before any same-cycle pop.
        overflow_d = overflow_q || (push && fifo_full);
    end

    // All receiver state, reset to idle line level and an empty frame.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
            idle_cnt_q  <= '0;
`endif
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
`ifdef PS2_RX_TIMEOUT_EN
            idle_cnt_q  <= idle_cnt_d;
`endif
        end
    end

    ps2_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .clrn    (clrn),
        .wr_en   (push),
        .wr_data (shift_q[8:1]),
        .rd_en   (!nextdata_n),
        .rd_data (data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign ready     = !fifo_empty;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule
